// File: rtl/move_entry_ctrl.sv
// Move-entry controller: debounces five push buttons, steers a wrapping
// cursor over a 5x5 board and issues a registered move strobe (active) with
// x/y held stable before, during and after the pulse.
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   btn_up/down/left/right  : raw asynchronous direction buttons (active-high)
//   btn_place               : raw asynchronous place button (active-high)
//   end_game[1:0]           : 3 = game in progress, 0/1/2 = finished
//   triangle_moves[95:0]    : 12 slots of {y[3:0], x[3:0]}, x = 4'hF is empty
//   circle_moves[95:0]      : 12 slots, same layout
//   blocked_squares[31:0]   : 4 slots, same layout
//   x, y                    : latched move coordinate
//   active                  : move strobe, high for PULSE_CYCLES cycles
//   cursor_x, cursor_y      : current cursor cell
//   cell_occupied           : combinational, cursor cell is in some slot
//   reject                  : one-cycle pulse when a place is refused
module move_entry_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned PULSE_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_place,
    input  logic [1:0]  end_game,
    input  logic [95:0] triangle_moves,
    input  logic [95:0] circle_moves,
    input  logic [31:0] blocked_squares,
    output logic [3:0]  x,
    output logic [3:0]  y,
    output logic        active,
    output logic [3:0]  cursor_x,
    output logic [3:0]  cursor_y,
    output logic        cell_occupied,
    output logic        reject
);

    localparam int unsigned NBTN    = 5;
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PW      = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int unsigned B_UP    = 0;
    localparam int unsigned B_DOWN  = 1;
    localparam int unsigned B_LEFT  = 2;
    localparam int unsigned B_RIGHT = 3;
    localparam int unsigned B_PLACE = 4;
    localparam logic [3:0]  EDGE_HI = 4'd4;
    localparam logic [3:0]  START   = 4'd2;
    localparam logic [3:0]  EMPTY   = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT_REL
    } state_t;

    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] sync_a;
    logic [NBTN-1:0] sync_b;
    logic [NBTN-1:0] level;
    logic [NBTN-1:0] press;
    logic [DB_W-1:0] db_cnt [NBTN];

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   pulse_cnt;
    logic [PW-1:0]   pulse_cnt_next;
    logic [3:0]      x_next;
    logic [3:0]      y_next;
    logic [3:0]      cur_x_next;
    logic [3:0]      cur_y_next;
    logic            active_next;
    logic            reject_next;

    assign raw = {btn_place, btn_right, btn_left, btn_down, btn_up};

    // Synchronize, debounce, and emit a one-cycle press on each accepted rise.
    // The counter tracks consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
            level  <= '0;
            press  <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            press  <= '0;
            for (int i = 0; i < NBTN; i++) begin
                if (sync_b[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level[i]  <= sync_b[i];
                    press[i]  <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Cursor cell lookup across every non-empty slot.
    always_comb begin
        cell_occupied = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (triangle_moves[8*k +: 4] != EMPTY &&
                triangle_moves[8*k +: 8] == {cursor_y, cursor_x}) begin
                cell_occupied = 1'b1;
            end
            if (circle_moves[8*k +: 4] != EMPTY &&
                circle_moves[8*k +: 8] == {cursor_y, cursor_x}) begin
                cell_occupied = 1'b1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (blocked_squares[8*k +: 4] != EMPTY &&
                blocked_squares[8*k +: 8] == {cursor_y, cursor_x}) begin
                cell_occupied = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next     = state;
        pulse_cnt_next = pulse_cnt;
        x_next         = x;
        y_next         = y;
        cur_x_next     = cursor_x;
        cur_y_next     = cursor_y;
        reject_next    = 1'b0;

        case (state)
            IDLE: begin
                // Place outranks every direction; a finished game always strobes.
                if (press[B_PLACE]) begin
                    if (end_game != 2'd3 || !cell_occupied) begin
                        x_next     = cursor_x;
                        y_next     = cursor_y;
                        state_next = SETUP;
                    end else begin
                        reject_next = 1'b1;
                    end
                end else if (press[B_UP]) begin
                    cur_y_next = (cursor_y == 4'd0) ? EDGE_HI : cursor_y - 4'd1;
                end else if (press[B_DOWN]) begin
                    cur_y_next = (cursor_y == EDGE_HI) ? 4'd0 : cursor_y + 4'd1;
                end else if (press[B_LEFT]) begin
                    cur_x_next = (cursor_x == 4'd0) ? EDGE_HI : cursor_x - 4'd1;
                end else if (press[B_RIGHT]) begin
                    cur_x_next = (cursor_x == EDGE_HI) ? 4'd0 : cursor_x + 4'd1;
                end
            end
            SETUP: begin
                pulse_cnt_next = '0;
                state_next     = PULSE;
            end
            PULSE: begin
                if (pulse_cnt == PW'(PULSE_CYCLES - 1)) begin
                    state_next = HOLD;
                end else begin
                    pulse_cnt_next = pulse_cnt + 1'b1;
                end
            end
            HOLD: begin
                state_next = WAIT_REL;
            end
            WAIT_REL: begin
                if (!level[B_PLACE]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Registered strobe: high exactly while the machine sits in PULSE.
        active_next = (state_next == PULSE);
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt <= '0;
            x         <= EMPTY;
            y         <= EMPTY;
            cursor_x  <= START;
            cursor_y  <= START;
            active    <= 1'b0;
            reject    <= 1'b0;
        end else begin
            pulse_cnt <= pulse_cnt_next;
            x         <= x_next;
            y         <= y_next;
            cursor_x  <= cur_x_next;
            cursor_y  <= cur_y_next;
            active    <= active_next;
            reject    <= reject_next;
        end
    end

endmodule

// File: doc/move_entry_ctrl.md
MOVE_ENTRY_CTRL -- requirements
Module: move_entry_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DEBOUNCE_CYCLES, 500000: consecutive stable samples needed to accept a button level.
- PULSE_CYCLES, 4: number of cycles that active is held high.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock. One clock; reset is asynchronous and active-low.
- rst_n, in, 1: asynchronous active-low reset.
- btn_up, btn_down, btn_left, btn_right, btn_place, in, 1 each: raw asynchronous buttons, active-high.
- end_game, in, 2: game status; 3 = in progress, 0/1/2 = finished.
- triangle_moves, circle_moves, in, 96 each: 12 packed slots each.
- blocked_squares, in, 32: 4 packed slots.
- x, y, out, 4 each: move coordinate presented to the game logic.
- active, out, 1: move strobe; the game logic samples x and y on its rising edge.
- cursor_x, cursor_y, out, 4 each: current cursor cell, for display.
- cell_occupied, out, 1: the cursor cell appears in any slot.
- reject, out, 1: one-cycle pulse when a place request is refused.

Function
REQ-003 Each button SHALL pass through a 2-flop synchronizer and then a debouncer; a debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-004 A press event SHALL be a single-cycle pulse on the 0->1 transition of a debounced level; a held button generates no further events.
REQ-005 Slot k SHALL occupy bits [8k+3:8k] = x and [8k+7:8k+4] = y; a slot with x = 4'hF is empty.
REQ-006 cell_occupied SHALL be combinational: 1 when any non-empty slot of triangle_moves, circle_moves or blocked_squares matches {cursor_y, cursor_x}.
REQ-007 The board SHALL be 5x5 (coordinates 0..4); cursor moves SHALL wrap: up at y=0 goes to 4, down at y=4 goes to 0; left and right wrap the same way on x.
REQ-008 Cursor movement SHALL occur only in IDLE, one cell per event, taking effect on the cycle after the event.
REQ-009 Direction priority in the same cycle SHALL be up > down > left > right; only one direction is applied per cycle.
REQ-010 If a place event and a direction event occur in the same cycle, place SHALL win and the direction SHALL be dropped.
REQ-011 The state machine SHALL have states IDLE, SETUP, PULSE, HOLD and WAIT_REL.
REQ-012 In IDLE, on a place event:
- if end_game != 3, or cell_occupied = 0: latch x = cursor_x, y = cursor_y, then go to SETUP;
- otherwise: assert reject for one cycle and stay in IDLE.
REQ-013 SETUP SHALL last 1 cycle with active = 0 (x and y stable before the rising edge), then go to PULSE.
REQ-014 PULSE SHALL hold active = 1 for exactly PULSE_CYCLES cycles, then go to HOLD.
REQ-015 HOLD SHALL last 1 cycle with active = 0 and x and y unchanged, then go to WAIT_REL.
REQ-016 WAIT_REL SHALL return to IDLE when the debounced btn_place = 0; events arriving during SETUP..WAIT_REL SHALL be discarded and not queued.
REQ-017 x and y SHALL change only on entry to SETUP and SHALL otherwise hold their last value.
REQ-018 A place while end_game != 3 SHALL issue a normal strobe (this is the new-game request), and the cursor SHALL NOT change.
REQ-019 active SHALL be driven directly from a flop, with no combinational path from any input.

Reset
REQ-020 While rst_n = 0, the block SHALL hold: state = IDLE, cursor_x = cursor_y = 2, x = y = 4'hF, active = 0, reject = 0, all debounced levels = 0, all debounce counters = 0.
REQ-021 Reset asserted mid-strobe SHALL force active = 0 immediately (asynchronously); no partial pulse SHALL resume after release.
REQ-022 A button held across reset release SHALL produce exactly one press event, after DEBOUNCE_CYCLES cycles.

Verification (bench uses DEBOUNCE_CYCLES = 4, PULSE_CYCLES = 4)
REQ-023 The bench SHALL cover at least these directed scenarios:
- Reset, then btn_right x3 and btn_down x1 -> cursor (0,3) after wrapping 2->3->4->0; active stays 0.
- All slots empty, end_game = 3, cursor (1,1), place -> x = 1, y = 1 one cycle before active rises; active high exactly 4 cycles; x and y stable for 1 cycle after the fall.
- triangle_moves[7:0] = 8'h11, cursor (1,1), place -> reject pulses 1 cycle; active stays 0.
- Same occupied cell with end_game = 1, place -> strobe issued; no reject.
- btn_place glitch lasting 3 cycles -> no event.
- btn_up and btn_place in the same cycle -> strobe issued; cursor unchanged.
- btn_left pressed during PULSE -> ignored.
- rst_n low during PULSE -> active = 0 in the same cycle; all outputs at their REQ-020 values.
